dtc_serial_rx: RTL and testbench

//  - Receive end of the DTC tester serial link: deserialises a 1-bit/clk stream into bytes.
//  - Stream is LSB-first: each byte is sent as bit0, then bit1, and so on.
//  - Finds word alignment by hunting for the alignment word, then presents aligned bytes.
//  - Flags frame starts and tracks loss of lock. Outputs feed ChipScope ILA/VIO probes.

---
 rtl/dtc_serial_rx.sv | 186 ++++++++++++++++++
 tb/tb_dtc_serial_rx.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dtc_serial_rx.sv
// DTC tester serial link receiver: hunts for ALIGN_WORD in an LSB-first stream, verifies
// frame alignment, then presents aligned bytes. Optional error counter: DTC_RX_ERRCNT_EN.
module dtc_serial_rx #(
   parameter logic [7:0]  ALIGN_WORD = 8'hF0,
   parameter int unsigned FRAME_LEN  = 1,
   parameter int unsigned LOCK_COUNT = 4,
   parameter int unsigned MISS_MAX   = 3
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        serial_in_i,
`ifdef DTC_RX_ERRCNT_EN
   input  logic        err_clr_i,
   output logic [15:0] err_cnt_o,
`endif
   output logic [7:0]  data_out_o,
   output logic        data_valid_o,
   output logic        frame_start_o,
   output logic        locked_o,
   output logic        align_err_o
);

   typedef enum logic [1:0] {HUNT = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} state_t;

   localparam logic [7:0] LAST_IDX        = 8'(FRAME_LEN - 32'd1);
   localparam logic [7:0] IDX_AFTER_ALIGN = 8'(32'd1 % FRAME_LEN);
   localparam logic [3:0] LOCK_C          = 4'(LOCK_COUNT);
   localparam logic [3:0] MISS_C          = 4'(MISS_MAX);

   function automatic logic [3:0] sat_inc4(input logic [3:0] v);
      sat_inc4 = (v == 4'hF) ? v : v + 4'd1;
   endfunction

   state_t     state_q, state_d;
   logic [7:0] sr_q, sr_nxt;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] word_idx_q, word_idx_d, word_idx_inc;
   logic [3:0] good_cnt_q, good_cnt_d, good_inc;
   logic [3:0] miss_cnt_q, miss_cnt_d, miss_inc;
   logic [7:0] data_out_q, data_out_d;
   logic       data_valid_q, data_valid_d;
   logic       frame_start_q, frame_start_d;
   logic       align_err_q, align_err_d;
   logic       locked_q;
   logic       match, boundary, idx0;

   // Next-state, counters and output strobes for the alignment FSM
   always_comb begin
      sr_nxt        = {serial_in_i, sr_q[7:1]};
      match         = (sr_nxt == ALIGN_WORD);
      boundary      = (bit_cnt_q == 3'd7);
      idx0          = (word_idx_q == 8'd0);
      word_idx_inc  = (word_idx_q == LAST_IDX) ? 8'd0 : word_idx_q + 8'd1;
      good_inc      = sat_inc4(good_cnt_q);
      miss_inc      = sat_inc4(miss_cnt_q);
      state_d       = state_q;
      bit_cnt_d     = bit_cnt_q + 3'd1;
      word_idx_d    = boundary ? word_idx_inc : word_idx_q;
      good_cnt_d    = good_cnt_q;
      miss_cnt_d    = miss_cnt_q;
      data_out_d    = data_out_q;
      data_valid_d  = 1'b0;
      frame_start_d = 1'b0;
      align_err_d   = 1'b0;
      case (state_q)
         HUNT: begin
            // bit_cnt is meaningless while hunting; a match restarts the word clock
            bit_cnt_d = 3'd0;
            if (match) begin
               word_idx_d = IDX_AFTER_ALIGN;
               good_cnt_d = 4'd1;
               if (LOCK_COUNT == 32'd1) begin
                  state_d    = LOCKED;
                  miss_cnt_d = 4'd0;
               end else begin
                  state_d = VERIFY;
               end
            end else begin
               word_idx_d = word_idx_q;
            end
         end
         VERIFY: begin
            if (boundary && idx0) begin
               if (match) begin
                  good_cnt_d = good_inc;
                  if (good_inc >= LOCK_C) begin
                     state_d    = LOCKED;
                     miss_cnt_d = 4'd0;
                  end else begin
                     state_d = VERIFY;
                  end
               end else begin
                  align_err_d = 1'b1;
                  state_d     = HUNT;
               end
            end else begin
               state_d = VERIFY;
            end
         end
         LOCKED: begin
            if (boundary) begin
               data_out_d    = sr_nxt;
               data_valid_d  = 1'b1;
               frame_start_d = idx0;
               if (idx0 && match) begin
                  miss_cnt_d = 4'd0;
               end else if (idx0) begin
                  align_err_d = 1'b1;
                  miss_cnt_d  = miss_inc;
                  state_d     = (miss_inc >= MISS_C) ? HUNT : LOCKED;
               end else begin
                  miss_cnt_d = miss_cnt_q;
               end
            end else begin
               state_d = LOCKED;
            end
         end
         default: begin
            state_d = HUNT;
         end
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= HUNT;
         sr_q          <= 8'd0;
         bit_cnt_q     <= 3'd0;
         word_idx_q    <= 8'd0;
         good_cnt_q    <= 4'd0;
         miss_cnt_q    <= 4'd0;
         data_out_q    <= 8'd0;
         data_valid_q  <= 1'b0;
         frame_start_q <= 1'b0;
         align_err_q   <= 1'b0;
         locked_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         sr_q          <= sr_nxt;
         bit_cnt_q     <= bit_cnt_d;
         word_idx_q    <= word_idx_d;
         good_cnt_q    <= good_cnt_d;
         miss_cnt_q    <= miss_cnt_d;
         data_out_q    <= data_out_d;
         data_valid_q  <= data_valid_d;
         frame_start_q <= frame_start_d;
         align_err_q   <= align_err_d;
         locked_q      <= (state_d == LOCKED);
      end
   end

   assign data_out_o    = data_out_q;
   assign data_valid_o  = data_valid_q;
   assign frame_start_o = frame_start_q;
   assign locked_o      = locked_q;
   assign align_err_o   = align_err_q;

`ifdef DTC_RX_ERRCNT_EN
   logic [15:0] err_cnt_q, err_cnt_d;

   // Count every non-ALIGN_WORD word received while locked; clear has priority
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (err_clr_i) begin
         err_cnt_d = 16'd0;
      end else if ((state_q == LOCKED) && boundary && !match && (err_cnt_q != 16'hFFFF)) begin
         err_cnt_d = err_cnt_q + 16'd1;
      end else begin
         err_cnt_d = err_cnt_q;
      end
   end

   // Error counter register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         err_cnt_q <= 16'd0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_dtc_serial_rx.sv
// Bench for dtc_serial_rx: table-driven lock sequence, hand-written slip/reset/false-lock
// sequences on a FRAME_LEN=1 instance, and randomized framed traffic on a FRAME_LEN=4 instance.
module tb_dtc_serial_rx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a = 1'b1, ser_a = 1'b0, rst_b = 1'b1, ser_b = 1'b0;
   logic [7:0] dout_a, dout_b;
   logic       dv_a, fs_a, lk_a, ae_a, dv_b, fs_b, lk_b, ae_b;
`ifdef DTC_RX_ERRCNT_EN
   logic        clr_a = 1'b0, clr_b = 1'b0;
   logic [15:0] ecnt_a, ecnt_b;
`endif

   int n_cmp  = 0;
   int n_fail = 0;
   int tx_pos_a = 0;
   int f0_seen  = 0;

   dtc_serial_rx u_a (
      .clk_i(clk), .rst_i(rst_a), .serial_in_i(ser_a),
`ifdef DTC_RX_ERRCNT_EN
      .err_clr_i(clr_a), .err_cnt_o(ecnt_a),
`endif
      .data_out_o(dout_a), .data_valid_o(dv_a), .frame_start_o(fs_a),
      .locked_o(lk_a), .align_err_o(ae_a)
   );

   dtc_serial_rx #(.FRAME_LEN(4)) u_b (
      .clk_i(clk), .rst_i(rst_b), .serial_in_i(ser_b),
`ifdef DTC_RX_ERRCNT_EN
      .err_clr_i(clr_b), .err_cnt_o(ecnt_b),
`endif
      .data_out_o(dout_b), .data_valid_o(dv_b), .frame_start_o(fs_b),
      .locked_o(lk_b), .align_err_o(ae_b)
   );

   typedef struct {
      logic [7:0] din;
      logic       dv;
      logic [7:0] dout;
      logic       fs;
      logic       err;
      logic       lk;
   } vec_t;

   vec_t tbl [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick_a(input logic b);
      @(negedge clk);
      ser_a = b;
      @(posedge clk);
      #1;
   endtask

   task automatic tick_b(input logic b);
      @(negedge clk);
      ser_b = b;
      @(posedge clk);
      #1;
   endtask

   task automatic send_a(input logic [7:0] b, output int mid);
      mid = 0;
      for (int i = 0; i < 8; i++) begin
         tick_a(b[i]);
         if (i < 7 && dv_a) mid++;
      end
   endtask

   task automatic f0_bit_a();
      tick_a(tx_pos_a >= 4);
      tx_pos_a = (tx_pos_a + 1) % 8;
   endtask

   task automatic reset_a();
      @(negedge clk);
      rst_a = 1'b1;
      ser_a = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_a = 1'b0;
      tx_pos_a = 0;
   endtask

   task automatic reset_b();
      @(negedge clk);
      rst_b = 1'b1;
      ser_b = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_b = 1'b0;
      f0_seen = 0;
   endtask

   // Word-level reference: lock is declared on the 4th index-0 ALIGN_WORD; every later word
   // is presented as sent, flagged as frame start only at index 0; no alignment errors.
   task automatic word_b(input logic [7:0] b, input int idx);
      int   mid;
      logic was_locked;
      was_locked = (f0_seen >= 4);
      if (idx == 0) f0_seen++;
      mid = 0;
      for (int i = 0; i < 8; i++) begin
         tick_b(b[i]);
         if (i < 7 && dv_b) mid++;
      end
      check("b_word", 32'({dv_b, (dv_b ? dout_b : 8'h00), fs_b, ae_b, lk_b, (mid == 0)}),
            32'({was_locked, (was_locked ? b : 8'h00), (was_locked && idx == 0), 1'b0,
                 (f0_seen >= 4), 1'b1}));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int       mid, n, early;
      logic [7:0] w;

      tbl[0] = '{8'hF0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{8'hF0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
      tbl[2] = '{8'hF0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
      tbl[3] = '{8'hF0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
      tbl[4] = '{8'hF0, 1'b1, 8'hF0, 1'b1, 1'b0, 1'b1};
      tbl[5] = '{8'hF0, 1'b1, 8'hF0, 1'b1, 1'b0, 1'b1};
      tbl[6] = '{8'hF1, 1'b1, 8'hF1, 1'b1, 1'b1, 1'b1};
      tbl[7] = '{8'hF0, 1'b1, 8'hF0, 1'b1, 1'b0, 1'b1};

      reset_a();
      check("reset_state", 32'({dout_a, dv_a, fs_a, lk_a, ae_a}), 32'd0);

      for (int k = 0; k < 8; k++) begin
         send_a(tbl[k].din, mid);
         check("lock_tbl", 32'({dv_a, dout_a, fs_a, ae_a, lk_a, (mid == 0)}),
               32'({tbl[k].dv, tbl[k].dout, tbl[k].fs, tbl[k].err, tbl[k].lk, 1'b1}));
      end

      // Slip: one extra 0 bit shifts the stream; boundaries now see E0, E1, E1
      tick_a(1'b0);
      for (int i = 0; i < 7; i++) f0_bit_a();
      check("slip_1", 32'({dv_a, dout_a, fs_a, ae_a, lk_a}), 32'({1'b1, 8'hE0, 1'b1, 1'b1, 1'b1}));
      for (int i = 0; i < 8; i++) f0_bit_a();
      check("slip_2", 32'({dv_a, dout_a, fs_a, ae_a, lk_a}), 32'({1'b1, 8'hE1, 1'b1, 1'b1, 1'b1}));
      for (int i = 0; i < 8; i++) f0_bit_a();
      check("slip_3", 32'({dv_a, dout_a, fs_a, ae_a, lk_a}), 32'({1'b1, 8'hE1, 1'b1, 1'b1, 1'b0}));
      n = 0;
      while (!lk_a && n < 40) begin
         f0_bit_a();
         n++;
      end
      check("slip_relock_cycles", 32'(n), 32'd25);
      send_a(8'hF0, mid);
      check("slip_after_relock", 32'({dv_a, dout_a, fs_a, ae_a, lk_a}), 32'({1'b1, 8'hF0, 1'b1, 1'b0, 1'b1}));

      // Reset mid-word while locked
      for (int i = 0; i < 3; i++) f0_bit_a();
      @(negedge clk);
      rst_a = 1'b1;
      ser_a = (tx_pos_a >= 4);
      tx_pos_a = (tx_pos_a + 1) % 8;
      @(posedge clk);
      #1;
      check("rst_mid_lock", 32'({dout_a, dv_a, fs_a, lk_a, ae_a}), 32'd0);
      rst_a = 1'b0;
      n = 0;
      early = 0;
      while (!lk_a && n < 64) begin
         f0_bit_a();
         if (dv_a) early++;
         n++;
      end
      check("rst_relock_cycles", 32'(n), 32'd28);
      check("rst_no_early_valid", 32'(early), 32'd0);

      // False lock: a single ALIGN_WORD followed by a wrong index-0 word
      reset_a();
      send_a(8'hF0, mid);
      check("false_lock_hunt_hit", 32'({dv_a, ae_a, lk_a}), 32'd0);
      send_a(8'hA5, mid);
      check("false_lock_err", 32'({dv_a, ae_a, lk_a}), 32'({1'b0, 1'b1, 1'b0}));
      for (int k = 0; k < 2; k++) begin
         send_a(8'h00, mid);
         check("false_lock_idle", 32'({dv_a, ae_a, lk_a}), 32'd0);
      end

`ifdef DTC_RX_ERRCNT_EN
      reset_a();
      for (int k = 0; k < 5; k++) send_a(8'hF0, mid);
      for (int k = 0; k < 5; k++) begin
         send_a(8'hF1, mid);
         send_a(8'hF0, mid);
      end
      check("errcnt_locked", 32'(lk_a), 32'd1);
      check("errcnt_five", 32'(ecnt_a), 32'd5);
      w = 8'hF1;
      for (int i = 0; i < 7; i++) tick_a(w[i]);
      clr_a = 1'b1;
      tick_a(w[7]);
      clr_a = 1'b0;
      check("errcnt_clr_wins", 32'({ecnt_a, ae_a}), 32'({16'd0, 1'b1}));
      send_a(8'hF0, mid);
      send_a(8'hF1, mid);
      check("errcnt_after_clr", 32'(ecnt_a), 32'd1);
`endif

      // Framed traffic, FRAME_LEN=4: directed F0,11,22,33 frames
      reset_b();
      for (int f = 0; f < 6; f++) begin
         word_b(8'hF0, 0);
         word_b(8'h11, 1);
         word_b(8'h22, 2);
         word_b(8'h33, 3);
      end

      // Randomized: random start phase and random payload bytes
      for (int r = 0; r < 3; r++) begin
         reset_b();
         n = int'($urandom_range(7, 0));
         for (int i = 0; i < n; i++) tick_b(1'b0);
         for (int f = 0; f < 7; f++) begin
            word_b(8'hF0, 0);
            for (int j = 1; j < 4; j++) begin
               w = 8'($urandom());
               word_b(w, j);
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
